score_display_mux: RTL and testbench

Time-multiplexed seven-segment driver for the score display, generalised to NUM_DIGITS digits sharing one segment bus. It adds programmable scan rate, a dead-time blanking window between digits to suppress ghosting, per-slot snapshotting of digit values, blanking of non-decimal codes, and a game-over blink. It sits between the game-state logic, which supplies per-digit BCD, and the board's segment and digit-select pins.

---
 rtl/score_display_mux.sv | 116 +++++++++++
 tb/tb_score_display_mux.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/score_display_mux.sv
// Multiplexed seven-segment driver: NUM_DIGITS digits share one segment bus, with
// programmable scan rate, per-slot dead time, per-slot digit snapshots and game-over blink.
module score_display_mux #(
  parameter int NUM_DIGITS  = 2,
  parameter int SCAN_DIV    = 1,
  parameter int DEAD_CYCLES = 0,
  parameter int BLINK_BITS  = 10,
  parameter int WIN_SCORE   = 9
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    game_over
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int P_W   = (SCAN_DIV > 0) ? SCAN_DIV : 1;
  localparam logic [P_W-1:0]   P_LAST   = P_W'((1 << SCAN_DIV) - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [3:0]       WIN4     = 4'(WIN_SCORE);

  logic [3:0]            digit_arr [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] digit_hit;
  logic                  game_over_int;
  logic                  active;
  logic                  lit;

  logic [P_W-1:0]        p_q, p_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [3:0]            snap_q, snap_d;
  logic [BLINK_BITS-1:0] blink_q, blink_d;
  logic                  load_q, load_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic                  game_over_q, game_over_d;

  // Only decimal codes light segments; A-F are deliberately blank.
  function automatic logic [6:0] decode_bcd(input logic [3:0] code);
    logic [6:0] pattern;
    case (code)
      4'd0:    pattern = 7'b0111111;
      4'd1:    pattern = 7'b0000110;
      4'd2:    pattern = 7'b1011011;
      4'd3:    pattern = 7'b1001111;
      4'd4:    pattern = 7'b1100110;
      4'd5:    pattern = 7'b1101101;
      4'd6:    pattern = 7'b1111101;
      4'd7:    pattern = 7'b0000111;
      4'd8:    pattern = 7'b1111111;
      4'd9:    pattern = 7'b1101111;
      default: pattern = 7'b0000000;
    endcase
    return pattern;
  endfunction

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign digit_arr[gi] = digits_in[4*gi +: 4];
      assign digit_hit[gi] = (digit_arr[gi] >= WIN4) && (digit_arr[gi] <= 4'd9);
    end
  endgenerate

  assign game_over_int = |digit_hit;

  always_comb begin
    p_d     = (SCAN_DIV == 0) ? '0 : p_q + P_W'(1);
    blink_d = blink_q + BLINK_BITS'(1);
    idx_d   = idx_q;
    snap_d  = snap_q;
    load_d  = 1'b0;
    // The first edge after reset loads digit 0 without advancing, so slot 0 is never skipped.
    if (load_q) begin
      snap_d = digit_arr[idx_q];
    end else if (p_q == P_LAST) begin
      idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      snap_d = digit_arr[idx_d];
    end
  end

  always_comb begin
    active      = (int'(p_q) >= DEAD_CYCLES);
    lit         = !game_over_int || blink_q[BLINK_BITS-1];
    sel_d       = active ? (NUM_DIGITS'(1) << idx_q) : '0;
    seg_d       = (active && lit) ? decode_bcd(snap_q) : 7'd0;
    game_over_d = game_over_int;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_q         <= '0;
      idx_q       <= '0;
      snap_q      <= '0;
      blink_q     <= '0;
      load_q      <= 1'b1;
      seg_q       <= '0;
      sel_q       <= '0;
      game_over_q <= 1'b0;
    end else begin
      p_q         <= p_d;
      idx_q       <= idx_d;
      snap_q      <= snap_d;
      blink_q     <= blink_d;
      load_q      <= load_d;
      seg_q       <= seg_d;
      sel_q       <= sel_d;
      game_over_q <= game_over_d;
    end
  end

  assign seg       = seg_q;
  assign digit_sel = sel_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_score_display_mux.sv
// Scoreboard bench for score_display_mux: two instances (fast 2-digit scan, slow 3-digit
// scan with dead time and lowered win score) checked cycle by cycle against a reference model.
module tb_score_display_mux;

  typedef struct packed {
    logic [6:0] seg;
    logic [7:0] sel;
    logic       go;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic [31:0] dig0, dig1;
  logic [7:0]  digits_a;
  logic [11:0] digits_b;
  logic [6:0]  seg_a, seg_b;
  logic [1:0]  sel_a;
  logic [2:0]  sel_b;
  logic        go_a, go_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // reference model parameters and state, index 0 = u_a, 1 = u_b
  int nd   [2] = '{2, 3};
  int sdiv [2] = '{0, 2};
  int dead [2] = '{0, 1};
  int bb   [2] = '{4, 4};
  int win  [2] = '{9, 5};
  int m_p [2], m_idx [2], m_snap [2], m_blink [2];
  bit m_first [2];
  exp_t q0[$], q1[$];

  assign digits_a = dig0[7:0];
  assign digits_b = dig1[11:0];

  score_display_mux #(.NUM_DIGITS(2), .SCAN_DIV(0), .DEAD_CYCLES(0), .BLINK_BITS(4), .WIN_SCORE(9)) u_a (
    .clk(clk), .reset_n(reset_n), .digits_in(digits_a),
    .seg(seg_a), .digit_sel(sel_a), .game_over(go_a)
  );

  score_display_mux #(.NUM_DIGITS(3), .SCAN_DIV(2), .DEAD_CYCLES(1), .BLINK_BITS(4), .WIN_SCORE(5)) u_b (
    .clk(clk), .reset_n(reset_n), .digits_in(digits_b),
    .seg(seg_b), .digit_sel(sel_b), .game_over(go_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int code);
    case (code)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111101;
      7: return 7'b0000111;
      8: return 7'b1111111;
      9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_p[u] = 0; m_idx[u] = 0; m_snap[u] = 0; m_blink[u] = 0; m_first[u] = 1'b1;
    end
    q0.delete();
    q1.delete();
  endtask

  // Predict the outputs of the coming edge from the current model state and live inputs.
  task automatic predict(input int u);
    logic [31:0] d;
    int   s, c;
    bit   go, act, lit;
    exp_t e;
    d  = (u == 0) ? dig0 : dig1;
    s  = 1 << sdiv[u];
    go = 1'b0;
    for (int k = 0; k < nd[u]; k++) begin
      c = int'((d >> (4*k)) & 32'hF);
      if (c >= win[u] && c <= 9) go = 1'b1;
    end
    act   = (m_p[u] >= dead[u]);
    lit   = !go || (((m_blink[u] >> (bb[u]-1)) & 1) == 1);
    e.seg = (act && lit) ? seg_of(m_snap[u]) : 7'd0;
    e.sel = act ? 8'(1 << m_idx[u]) : 8'd0;
    e.go  = go;
    if (u == 0) q0.push_back(e); else q1.push_back(e);
    m_blink[u] = (m_blink[u] + 1) % (1 << bb[u]);
    if (m_first[u]) begin
      m_snap[u]  = int'((d >> (4*m_idx[u])) & 32'hF);
      m_first[u] = 1'b0;
    end else if (m_p[u] == s - 1) begin
      m_idx[u]  = (m_idx[u] == nd[u] - 1) ? 0 : m_idx[u] + 1;
      m_snap[u] = int'((d >> (4*m_idx[u])) & 32'hF);
    end
    m_p[u] = (m_p[u] + 1) % s;
  endtask

  task automatic tick();
    exp_t e;
    predict(0);
    predict(1);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    e = q0.pop_front();
    check_eq($sformatf("a.seg@%0d", cyc), 32'(seg_a), 32'(e.seg));
    check_eq($sformatf("a.sel@%0d", cyc), 32'(sel_a), 32'(e.sel));
    check_eq($sformatf("a.go@%0d", cyc),  32'(go_a),  32'(e.go));
    e = q1.pop_front();
    check_eq($sformatf("b.seg@%0d", cyc), 32'(seg_b), 32'(e.seg));
    check_eq($sformatf("b.sel@%0d", cyc), 32'(sel_b), 32'(e.sel));
    check_eq($sformatf("b.go@%0d", cyc),  32'(go_b),  32'(e.go));
    $display("cyc %0d a: dig=%h sel=%b seg=%b go=%b | b: dig=%h sel=%b seg=%b go=%b",
             cyc, digits_a, sel_a, seg_a, go_a, digits_b, sel_b, seg_b, go_b);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".a.seg"}, 32'(seg_a), 32'd0);
    check_eq({tag, ".a.sel"}, 32'(sel_a), 32'd0);
    check_eq({tag, ".a.go"},  32'(go_a),  32'd0);
    check_eq({tag, ".b.seg"}, 32'(seg_b), 32'd0);
    check_eq({tag, ".b.sel"}, 32'(sel_b), 32'd0);
    check_eq({tag, ".b.go"},  32'(go_b),  32'd0);
  endtask

  initial begin
    reset_n = 1'b1;
    dig0    = 32'h35;
    dig1    = 32'h012;
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    model_reset();

    // steady scan: fast alternation on u_a, dead-time slots on u_b
    repeat (13) tick();
    // mid-slot change of digit 0 on u_b: 2 -> 7
    dig1 = 32'h017;
    repeat (16) tick();
    // non-decimal codes blank; 9 on u_a forces game-over blink
    dig0 = 32'h9A;
    dig1 = 32'h0F3;
    repeat (40) tick();
    // u_b with WIN_SCORE=5: steady, then game-over blink
    dig1 = 32'h034;
    repeat (8) tick();
    dig1 = 32'h035;
    repeat (24) tick();

    // asynchronous reset mid-slot, outputs must clear without a clock edge
    #2 reset_n = 1'b0;
    #1 check_all_zero("async_rst");
    @(posedge clk);
    @(negedge clk);
    check_all_zero("rst_hold");
    reset_n = 1'b1;
    model_reset();
    repeat (12) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
